vend_dispense_responder: RTL and testbench

- Responder end of the vending controller's start/active handshake.
- The controller FSM raises a dispense request carrying an item code and a change count.
- This block drives the item motor for a fixed time, then emits one coin pulse per change unit, then acknowledges.
- Sits between the vending control FSM and the motor/coin-hopper drivers.

---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_pulse_timer.sv | 29 ++
 rtl/vend_dispense_responder.sv | 130 +++++++++++++
 tb/tb_vend_dispense_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and default sizing for the vending dispense responder.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOTOR  = 3'd1,
    ST_CHANGE = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } vend_state_e;

  localparam int ITEM_W_DEF       = 3;
  localparam int CHG_W_DEF        = 4;
  localparam int MOTOR_CYCLES_DEF = 4;
  localparam int COIN_GAP_DEF     = 2;

  // Timer width; covers MOTOR_CYCLES and COIN_GAP values up to 256.
  localparam int TIMER_W = 8;

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module vend_pulse_timer
  import vend_pkg::*;
#(
  parameter int CNT_W = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vend_dispense_responder.sv
// Dispense responder: runs the item motor, ejects change coins with gaps,
// then holds ack until the controller drops req.
//
//   state  | meaning
//   IDLE   | waiting for req; latches item/change on the sampling edge
//   MOTOR  | motor_en high for MOTOR_CYCLES cycles
//   CHANGE | one coin pulse; coins_left decrements at the end of the cycle
//   GAP    | COIN_GAP quiet cycles between coin pulses
//   DONE   | ack held high until req is seen low
module vend_dispense_responder
  import vend_pkg::*;
#(
  parameter int ITEM_W       = ITEM_W_DEF,
  parameter int CHG_W        = CHG_W_DEF,
  parameter int MOTOR_CYCLES = MOTOR_CYCLES_DEF,
  parameter int COIN_GAP     = COIN_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ITEM_W-1:0] item,
  input  logic [CHG_W-1:0]  change,
  output logic              busy,
  output logic              motor_en,
  output logic [ITEM_W-1:0] motor_sel,
  output logic              coin_pulse,
  output logic              ack,
  output logic [CHG_W-1:0]  coins_left
);

  // Timers are loaded with N-1 so the state is left in the cycle the count reads zero.
  localparam logic [TIMER_W-1:0] MOT_LOAD = TIMER_W'(MOTOR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(COIN_GAP - 1);

  vend_state_e       state_q, state_d;
  logic [CHG_W-1:0]  coins_d;
  logic [ITEM_W-1:0] sel_d;
  logic              mot_load, mot_dec, mot_zero;
  logic              gap_load, gap_dec, gap_zero;

  vend_pulse_timer #(.CNT_W(TIMER_W)) u_motor_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (mot_load),
    .load_val (MOT_LOAD),
    .dec      (mot_dec),
    .zero     (mot_zero)
  );

  vend_pulse_timer #(.CNT_W(TIMER_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d  = state_q;
    coins_d  = coins_left;
    sel_d    = motor_sel;
    mot_load = 1'b0;
    mot_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          sel_d    = item;
          coins_d  = change;
          mot_load = 1'b1;
          state_d  = ST_MOTOR;
        end
      end
      ST_MOTOR: begin
        if (mot_zero) begin
          state_d = (coins_left == '0) ? ST_DONE : ST_CHANGE;
        end else begin
          mot_dec = 1'b1;
        end
      end
      ST_CHANGE: begin
        // Only entered with coins_left >= 1, so this cannot underflow.
        coins_d = coins_left - CHG_W'(1);
        if (coins_left == CHG_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          gap_load = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_d = ST_CHANGE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (!req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      motor_en   <= 1'b0;
      coin_pulse <= 1'b0;
      ack        <= 1'b0;
      coins_left <= '0;
      motor_sel  <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != ST_IDLE);
      motor_en   <= (state_d == ST_MOTOR);
      coin_pulse <= (state_d == ST_CHANGE);
      ack        <= (state_d == ST_DONE);
      coins_left <= coins_d;
      motor_sel  <= sel_d;
    end
  end

endmodule

// File: tb/tb_vend_dispense_responder.sv
// Self-checking bench: expected per-cycle output records are queued when a
// request is driven and popped against the DUT on each falling edge.
module tb_vend_dispense_responder;

  localparam int MC  = 4;
  localparam int GAP = 2;

  typedef struct packed {
    logic       busy;
    logic       motor;
    logic       coin;
    logic       ack;
    logic [3:0] coins;
    logic [2:0] sel;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [2:0] item = '0;
  logic [3:0] change = '0;
  logic       busy, motor_en, coin_pulse, ack;
  logic [2:0] motor_sel;
  logic [3:0] coins_left;

  int   checks = 0;
  int   failures = 0;
  rec_t sb[$];

  always #5 clk = ~clk;

  vend_dispense_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .item       (item),
    .change     (change),
    .busy       (busy),
    .motor_en   (motor_en),
    .motor_sel  (motor_sel),
    .coin_pulse (coin_pulse),
    .ack        (ack),
    .coins_left (coins_left)
  );

  function automatic rec_t observe();
    rec_t r;
    r.busy  = busy;
    r.motor = motor_en;
    r.coin  = coin_pulse;
    r.ack   = ack;
    r.coins = coins_left;
    r.sel   = motor_sel;
    return r;
  endfunction

  function automatic rec_t mk(logic b, logic m, logic c, logic a, logic [3:0] n, logic [2:0] s);
    rec_t r;
    r.busy = b; r.motor = m; r.coin = c; r.ack = a; r.coins = n; r.sel = s;
    return r;
  endfunction

  // Expected trace: motor phase, pulse/gap train, 1+hold DONE cycles, then one IDLE cycle.
  task automatic push_txn(input logic [2:0] it, input int n, input int hold);
    for (int k = 0; k < MC; k++) sb.push_back(mk(1, 1, 0, 0, 4'(n), it));
    for (int i = 0; i < n; i++) begin
      sb.push_back(mk(1, 0, 1, 0, 4'(n - i), it));
      if (i < n - 1)
        for (int g = 0; g < GAP; g++) sb.push_back(mk(1, 0, 0, 0, 4'(n - i - 1), it));
    end
    for (int d = 0; d <= hold; d++) sb.push_back(mk(1, 0, 0, 1, 4'd0, it));
    sb.push_back(mk(0, 0, 0, 0, 4'd0, it));
  endtask

  task automatic test_reset();
    rec_t o, e;
    rst = 1'b0; req = 1'b1; item = 3'd5; change = 4'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = observe(); e = '0; checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h expected=%h", i, o, e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    o = observe(); e = mk(1, 1, 0, 0, 4'd3, 3'd5); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_release_start got=%h expected=%h", o, e);
    end
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    o = observe(); e = '0; checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_abort_motor got=%h expected=%h", o, e);
    end
    rst = 1'b1;
    @(negedge clk);
    o = observe(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_idle_after got=%h expected=%h", o, e);
    end
  endtask

  task automatic test_zero_change();
    rec_t o, e;
    int   cyc = 0, motor_cnt = 0;
    item = 3'd5; change = 4'd0; req = 1'b1;
    push_txn(3'd5, 0, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      cyc++;
      o = observe(); e = sb.pop_front(); checks++;
      if (o.motor) motor_cnt++;
      if (o !== e) begin
        failures++;
        $display("FAIL zero_change cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      if (sb.size() == 1) req = 1'b0;
    end
    checks++;
    if (motor_cnt !== MC) begin
      failures++;
      $display("FAIL zero_change_motor_cycles got=%0d expected=%0d", motor_cnt, MC);
    end
  endtask

  task automatic test_three_coins();
    rec_t o, e;
    int   cyc = 0, pulses = 0;
    item = 3'd2; change = 4'd3; req = 1'b1;
    push_txn(3'd2, 3, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      cyc++;
      o = observe(); e = sb.pop_front(); checks++;
      if (o.coin) pulses++;
      if (o !== e) begin
        failures++;
        $display("FAIL three_coins cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      if (sb.size() == 1) req = 1'b0;
    end
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL three_coins_pulse_count got=%0d expected=3", pulses);
    end
  endtask

  task automatic test_held_req();
    rec_t o, e;
    int   cyc = 0, pulses = 0;
    item = 3'd2; change = 4'd3; req = 1'b1;
    push_txn(3'd2, 3, 10);
    while (sb.size() > 0) begin
      @(negedge clk);
      cyc++;
      o = observe(); e = sb.pop_front(); checks++;
      if (o.coin) pulses++;
      if (o !== e) begin
        failures++;
        $display("FAIL held_req cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      if (cyc == 3) begin
        item = 3'd7; change = 4'd9;
      end
      if (sb.size() == 1) req = 1'b0;
    end
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL held_req_pulse_count got=%0d expected=3", pulses);
    end
  endtask

  task automatic test_reset_mid_change();
    rec_t o, e;
    int   cyc = 0, pulses = 0;
    item = 3'd1; change = 4'd3; req = 1'b1;
    push_txn(3'd1, 3, 0);
    while (sb.size() > 0 && pulses < 2) begin
      @(negedge clk);
      cyc++;
      o = observe(); e = sb.pop_front(); checks++;
      if (o.coin) pulses++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_change cyc=%0d got=%h expected=%h", cyc, o, e);
      end
    end
    sb.delete();
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    o = observe(); e = '0; checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL mid_change_reset got=%h expected=%h", o, e);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_change_no_third_pulse[%0d] got=%h expected=%h", i, o, e);
      end
    end
  endtask

  task automatic test_max_change();
    rec_t o, e;
    int   cyc = 0, pulses = 0;
    logic prev_coin = 1'b0;
    item = 3'd6; change = 4'd15; req = 1'b1;
    push_txn(3'd6, 15, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      cyc++;
      o = observe(); e = sb.pop_front(); checks++;
      if (o.coin) pulses++;
      if (o !== e) begin
        failures++;
        $display("FAIL max_change cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      if (prev_coin && o.coin) begin
        failures++;
        $display("FAIL max_change_adjacent_pulse cyc=%0d got=1 expected=0", cyc);
      end
      prev_coin = o.coin;
      if (sb.size() == 1) req = 1'b0;
    end
    checks++;
    if (pulses !== 15) begin
      failures++;
      $display("FAIL max_change_pulse_count got=%0d expected=15", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_zero_change();
    test_three_coins();
    test_held_req();
    test_reset_mid_change();
    test_max_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
